// File: rtl/core_exu_pkg.sv
// Shared execute-unit definitions: divide-controller state encoding and
// DIV/DIVU/REM/REMU funct codes with small decode helpers.
package core_exu_pkg;

  typedef enum logic [2:0] {
    DIVC_IDLE  = 3'd0,
    DIVC_START = 3'd1,
    DIVC_WAIT  = 3'd2,
    DIVC_WB    = 3'd3,
    DIVC_DRAIN = 3'd4
  } divc_state_e;

  typedef enum logic [1:0] {
    DIV_F_DIV  = 2'b00,
    DIV_F_DIVU = 2'b01,
    DIV_F_REM  = 2'b10,
    DIV_F_REMU = 2'b11
  } div_funct_e;

  // Bit 0 of funct marks the unsigned variants, bit 1 the remainder variants.
  function automatic logic funct_is_signed(input logic [1:0] funct);
    return ~funct[0];
  endfunction

  function automatic logic funct_is_quot(input logic [1:0] funct);
    return ~funct[1];
  endfunction

endpackage

// File: rtl/core_exu_div_prep.sv
// Combinational operand preparation for the iterative divider: magnitudes,
// quotient/remainder sign-correction flags and quotient/remainder select.
module core_exu_div_prep
  import core_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      funct_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] mag1_o,
  output logic [XLEN-1:0] mag2_o,
  output logic            q_sign_o,
  output logic            r_sign_o,
  output logic            op_o
);

  logic is_signed;
  logic neg1;
  logic neg2;

  assign is_signed = funct_is_signed(funct_i);
  assign neg1      = is_signed & rs1_i[XLEN-1];
  assign neg2      = is_signed & rs2_i[XLEN-1];

  assign mag1_o = neg1 ? -rs1_i : rs1_i;
  assign mag2_o = neg2 ? -rs2_i : rs2_i;

  // A zero divisor keeps the all-ones quotient positive; the remainder sign
  // follows the dividend so x/0 naturally returns x as remainder.
  assign q_sign_o = is_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) & (|rs2_i);
  assign r_sign_o = neg1;
  assign op_o     = funct_is_quot(funct_i);

endmodule

// File: rtl/core_exu_div_ctrl.sv
// Sequencing controller between execute and the iterative divider: accept,
// start, wait, writeback handshake and flush draining.
// Optional last-result cache enabled by defining CORE_DIV_RESULT_CACHE_EN.
module core_exu_div_ctrl
  import core_exu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_i,
  input  logic [1:0]      funct_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RW-1:0]   rd_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_data1_o,
  output logic [XLEN-1:0] div_data2_o,
  output logic            div_op_o,
  output logic            div_q_sign_o,
  output logic            div_r_sign_o,
  output logic [RW-1:0]   div_waddr_o,
  input  logic [XLEN-1:0] div_data_i,
  input  logic            div_vld_i,
  output logic            wb_req_o,
  output logic [RW-1:0]   wb_waddr_o,
  output logic [XLEN-1:0] wb_data_o,
  input  logic            wb_gnt_i
);

  divc_state_e     state_q, state_d;
  logic [XLEN-1:0] data1_q, data1_d;
  logic [XLEN-1:0] data2_q, data2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            op_q, op_d;
  logic            q_sign_q, q_sign_d;
  logic            r_sign_q, r_sign_d;
  logic [RW-1:0]   rd_q, rd_d;

  logic [XLEN-1:0] mag1, mag2;
  logic            q_sign, r_sign, op;
  logic            accept;
  logic            cache_hit;

  core_exu_div_prep #(.XLEN(XLEN)) u_prep (
    .funct_i  (funct_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .mag1_o   (mag1),
    .mag2_o   (mag2),
    .q_sign_o (q_sign),
    .r_sign_o (r_sign),
    .op_o     (op)
  );

  assign accept = (state_q == DIVC_IDLE) & req_i & ~flush_i;

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    op_d     = op_q;
    q_sign_d = q_sign_q;
    r_sign_d = r_sign_q;
    rd_d     = rd_q;
    result_d = result_q;

    if (accept) begin
      data1_d  = mag1;
      data2_d  = mag2;
      op_d     = op;
      q_sign_d = q_sign;
      r_sign_d = r_sign;
      rd_d     = rd_i;
    end

    case (state_q)
      DIVC_IDLE:  if (accept) state_d = cache_hit ? DIVC_WB : DIVC_START;
      DIVC_START: state_d = flush_i ? DIVC_IDLE : DIVC_WAIT;
      DIVC_WAIT: begin
        // A result arriving with the flush needs no draining.
        if (flush_i) begin
          state_d = div_vld_i ? DIVC_IDLE : DIVC_DRAIN;
        end else if (div_vld_i) begin
          result_d = div_data_i;
          state_d  = DIVC_WB;
        end
      end
      DIVC_WB:    if (flush_i || wb_gnt_i) state_d = DIVC_IDLE;
      DIVC_DRAIN: if (div_vld_i) state_d = DIVC_IDLE;
      default:    state_d = DIVC_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= DIVC_IDLE;
      data1_q  <= '0;
      data2_q  <= '0;
      op_q     <= 1'b0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      op_q     <= op_d;
      q_sign_q <= q_sign_d;
      r_sign_q <= r_sign_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

`ifdef CORE_DIV_RESULT_CACHE_EN
  // result_q doubles as the cached result; the tag is refreshed on every
  // accept and only marked valid once that operation's result is captured.
  logic            cache_vld_q, cache_vld_d;
  logic [1:0]      cache_funct_q, cache_funct_d;
  logic [XLEN-1:0] cache_rs1_q, cache_rs1_d;
  logic [XLEN-1:0] cache_rs2_q, cache_rs2_d;

  assign cache_hit = cache_vld_q && (cache_funct_q == funct_i) &&
                     (cache_rs1_q == rs1_i) && (cache_rs2_q == rs2_i);

  always_comb begin
    cache_vld_d   = cache_vld_q;
    cache_funct_d = cache_funct_q;
    cache_rs1_d   = cache_rs1_q;
    cache_rs2_d   = cache_rs2_q;
    if (accept) begin
      cache_funct_d = funct_i;
      cache_rs1_d   = rs1_i;
      cache_rs2_d   = rs2_i;
    end
    if (flush_i && (state_q == DIVC_START || state_q == DIVC_WAIT)) begin
      cache_vld_d = 1'b0;
    end else if (state_q == DIVC_WAIT && div_vld_i) begin
      cache_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cache_vld_q   <= 1'b0;
      cache_funct_q <= '0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
    end else begin
      cache_vld_q   <= cache_vld_d;
      cache_funct_q <= cache_funct_d;
      cache_rs1_q   <= cache_rs1_d;
      cache_rs2_q   <= cache_rs2_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  assign div_start_o  = (state_q == DIVC_START) & ~flush_i;
  assign div_data1_o  = data1_q;
  assign div_data2_o  = data2_q;
  assign div_op_o     = op_q;
  assign div_q_sign_o = q_sign_q;
  assign div_r_sign_o = r_sign_q;
  assign div_waddr_o  = rd_q;

  assign wb_req_o   = (state_q == DIVC_WB);
  assign wb_waddr_o = rd_q;
  assign wb_data_o  = wb_req_o ? result_q : '0;

  assign hold_o = accept | (state_q == DIVC_START) | (state_q == DIVC_WAIT) |
                  ((state_q == DIVC_WB) & ~wb_gnt_i);

endmodule

// File: tb/tb_core_exu_div_ctrl.sv
// Self-checking bench for core_exu_div_ctrl with a behavioural divider model
// (33-cycle normal latency, 1-cycle early-out) and a writeback scoreboard.
module tb_core_exu_div_ctrl;
  import core_exu_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            req_i;
  logic [1:0]      funct_i;
  logic [XLEN-1:0] rs1_i, rs2_i;
  logic [RW-1:0]   rd_i;
  logic            flush_i;
  logic            hold_o, div_start_o, div_op_o, div_q_sign_o, div_r_sign_o;
  logic [XLEN-1:0] div_data1_o, div_data2_o, div_data_i;
  logic [RW-1:0]   div_waddr_o, wb_waddr_o;
  logic            div_vld_i, wb_req_o, wb_gnt_i;
  logic [XLEN-1:0] wb_data_o;

  core_exu_div_ctrl #(.XLEN(XLEN), .RW(RW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .funct_i(funct_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .hold_o(hold_o), .div_start_o(div_start_o), .div_data1_o(div_data1_o),
    .div_data2_o(div_data2_o), .div_op_o(div_op_o), .div_q_sign_o(div_q_sign_o),
    .div_r_sign_o(div_r_sign_o), .div_waddr_o(div_waddr_o), .div_data_i(div_data_i),
    .div_vld_i(div_vld_i), .wb_req_o(wb_req_o), .wb_waddr_o(wb_waddr_o),
    .wb_data_o(wb_data_o), .wb_gnt_i(wb_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  funct;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic [31:0] mag1, mag2;
    logic        qs, rs, op;
    logic [31:0] wb;
    int          lat;     // posedges after the accept edge until wb_req_o
    int          gnt_dly; // cycles wb_gnt_i stays low
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt;
  int   mdl_cnt;
  logic [31:0] mdl_res;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] div_model(input logic [31:0] d1, input logic [31:0] d2,
                                            input logic op, input logic qs, input logic rs);
    logic [31:0] q, r;
    q = (d2 == 0) ? 32'hFFFF_FFFF : d1 / d2;
    r = (d2 == 0) ? d1 : d1 % d2;
    return op ? (qs ? -q : q) : (rs ? -r : r);
  endfunction

  // Divider model: early-out answers in the cycle after start, otherwise 33.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_vld_i  <= 1'b0;
      div_data_i <= '0;
      mdl_cnt    <= 0;
      mdl_res    <= '0;
      start_cnt  <= 0;
    end else begin
      div_vld_i <= 1'b0;
      if (div_start_o) begin
        start_cnt <= start_cnt + 1;
        if (div_data2_o == 0 || div_data2_o > div_data1_o) begin
          div_vld_i  <= 1'b1;
          div_data_i <= div_model(div_data1_o, div_data2_o, div_op_o, div_q_sign_o, div_r_sign_o);
        end else begin
          mdl_cnt <= 32;
          mdl_res <= div_model(div_data1_o, div_data2_o, div_op_o, div_q_sign_o, div_r_sign_o);
        end
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          div_vld_i  <= 1'b1;
          div_data_i <= mdl_res;
        end
      end
    end
  end

  task automatic add_vec(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] m1, input logic [31:0] m2,
                         input logic qs, input logic rs, input logic op,
                         input logic [31:0] wb, input int lat, input int gd);
    vec_t v;
    v.funct = f; v.rs1 = a; v.rs2 = b; v.rd = rd; v.mag1 = m1; v.mag2 = m2;
    v.qs = qs; v.rs = rs; v.op = op; v.wb = wb; v.lat = lat; v.gnt_dly = gd;
    vecs.push_back(v);
  endtask

  // Entered and left at #1 after a posedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    int   lat;
    int   starts0;
    exp_t e;
    starts0 = start_cnt;
    req_i = 1'b1; funct_i = v.funct; rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
    sb.push_back('{rd: v.rd, data: v.wb});
    @(negedge clk_i);
    check({tag, "_hold_on_req"}, hold_o, 1);
    @(posedge clk_i); #1;
    req_i = 1'b0; rs1_i = '0; rs2_i = '0;
    @(negedge clk_i);
    check({tag, "_start"}, div_start_o, (v.lat != 0) ? 1 : 0);
    check({tag, "_data1"}, div_data1_o, v.mag1);
    check({tag, "_data2"}, div_data2_o, v.mag2);
    check({tag, "_flags"}, {div_op_o, div_q_sign_o, div_r_sign_o}, {v.op, v.qs, v.rs});
    check({tag, "_div_waddr"}, div_waddr_o, v.rd);
    lat = 0;
    while (!wb_req_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, "_wb_latency"}, lat, v.lat);
    check({tag, "_start_count"}, start_cnt - starts0, (v.lat != 0) ? 1 : 0);
    if (wb_req_o) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < v.gnt_dly; k++) begin
          @(negedge clk_i);
          check({tag, "_wait_req"}, wb_req_o, 1);
          check({tag, "_wait_hold"}, hold_o, 1);
          check({tag, "_wait_data"}, wb_data_o, e.data);
          @(posedge clk_i); #1;
        end
        wb_gnt_i = 1'b1;
        @(negedge clk_i);
        check({tag, "_wb_waddr"}, wb_waddr_o, e.rd);
        check({tag, "_wb_data"}, wb_data_o, e.data);
        check({tag, "_gnt_hold"}, hold_o, 0);
        @(posedge clk_i); #1;
        wb_gnt_i = 1'b0;
        check({tag, "_req_drop"}, wb_req_o, 0);
        check({tag, "_data_zero"}, wb_data_o, 0);
      end
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic saw_wb;
    int   starts0;

    rst_n_i = 1'b0; req_i = 1'b0; funct_i = '0; rs1_i = '0; rs2_i = '0;
    rd_i = '0; flush_i = 1'b0; wb_gnt_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_hold", hold_o, 0);
    check("rst_wb_req", wb_req_o, 0);
    check("rst_start", div_start_o, 0);
    check("rst_data1", div_data1_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    add_vec(DIV_F_DIV,  32'd100,       32'hFFFF_FFF9, 5'd3,  32'd100,       32'd7, 1, 0, 1, 32'hFFFF_FFF2, 34, 0);
    add_vec(DIV_F_REM,  32'hFFFF_FF9C, 32'd7,         5'd4,  32'd100,       32'd7, 1, 1, 0, 32'hFFFF_FFFE, 34, 2);
    add_vec(DIV_F_DIVU, 32'd5,         32'd0,         5'd5,  32'd5,         32'd0, 0, 0, 1, 32'hFFFF_FFFF, 2,  0);
    add_vec(DIV_F_REM,  32'd5,         32'd0,         5'd6,  32'd5,         32'd0, 0, 0, 0, 32'd5,         2,  1);
    add_vec(DIV_F_DIV,  32'hFFFF_FFFB, 32'd0,         5'd7,  32'd5,         32'd0, 0, 1, 1, 32'hFFFF_FFFF, 2,  0);
    add_vec(DIV_F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 32'd1, 0, 1, 1, 32'h8000_0000, 34, 0);
    add_vec(DIV_F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 32'd1, 0, 1, 0, 32'd0,         34, 3);
    add_vec(DIV_F_REMU, 32'hFFFF_FFF5, 32'h10,        5'd10, 32'hFFFF_FFF5, 32'h10, 0, 0, 0, 32'd5,        34, 0);
    add_vec(DIV_F_DIVU, 32'd3,         32'd7,         5'd11, 32'd3,         32'd7, 0, 0, 1, 32'd0,         2,  0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Flush in IDLE together with a request: not accepted.
    req_i = 1'b1; flush_i = 1'b1; funct_i = DIV_F_DIVU; rs1_i = 32'd9; rs2_i = 32'd2;
    @(negedge clk_i);
    check("idle_flush_hold", hold_o, 0);
    @(posedge clk_i); #1;
    req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("idle_flush_start", div_start_o, 0);
    @(posedge clk_i); #1;

    // Flush in START: start pulse suppressed, no writeback.
    starts0 = start_cnt;
    req_i = 1'b1; funct_i = DIV_F_DIV; rs1_i = 32'd50; rs2_i = 32'd5; rd_i = 5'd12;
    @(posedge clk_i); #1;
    req_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    check("start_flush_pulse", div_start_o, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("start_flush_hold", hold_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("start_flush_no_start", start_cnt - starts0, 0);
    check("start_flush_no_wb", wb_req_o, 0);

    // Flush at T+10 of a long divide: DRAIN until the divider result.
    req_i = 1'b1; funct_i = DIV_F_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd13;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("drain_hold_t10", hold_o, 1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("drain_hold_t11", hold_o, 0);
    n = 0; saw_wb = 1'b0;
    while (!div_vld_i && n < 60) begin
      @(negedge clk_i);
      if (wb_req_o) saw_wb = 1'b1;
      n++;
    end
    check("drain_vld_seen", div_vld_i, 1);
    repeat (2) begin
      @(posedge clk_i); #1;
      if (wb_req_o) saw_wb = 1'b1;
    end
    check("drain_no_wb", saw_wb, 0);
    run_vec(vecs[0], "after_drain");

    // Flush in WB: request dropped without a grant.
    req_i = 1'b1; funct_i = DIV_F_DIVU; rs1_i = 32'd5; rs2_i = 32'd0; rd_i = 5'd14;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n = 0;
    while (!wb_req_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("wbflush_req_seen", wb_req_o, 1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("wbflush_req_drop", wb_req_o, 0);
    check("wbflush_data_zero", wb_data_o, 0);
    check("wbflush_hold", hold_o, 0);

`ifdef CORE_DIV_RESULT_CACHE_EN
    begin
      vec_t c;
      c.funct = DIV_F_DIVU; c.rs1 = 32'd1000; c.rs2 = 32'd3; c.rd = 5'd15;
      c.mag1 = 32'd1000; c.mag2 = 32'd3; c.qs = 0; c.rs = 0; c.op = 1;
      c.wb = 32'd333; c.lat = 34; c.gnt_dly = 0;
      run_vec(c, "cache_miss");
      c.rd = 5'd16; c.lat = 0; c.gnt_dly = 5;
      run_vec(c, "cache_hit");
    end
`endif

    // Reset in the middle of an operation returns everything to zero.
    req_i = 1'b1; funct_i = DIV_F_DIV; rs1_i = 32'd77; rs2_i = 32'd2; rd_i = 5'd17;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("midrst_hold", hold_o, 0);
    check("midrst_data1", div_data1_o, 0);
    check("midrst_waddr", div_waddr_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check("midrst_no_wb", wb_req_o, 0);

    check("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
